scan_sequencer: RTL



---
 rtl/hub75_pkg.sv | 26 ++
 rtl/gamma_lut.sv | 40 ++++
 rtl/scan_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB-75 scan path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: panel geometry constants, scan FSM state enum, packed pixel struct.
package hub75_pkg;

    localparam int kCols          = 64;
    localparam int kHalfRows      = 32;
    localparam int kLineAddrWidth = 7;
    localparam int kPixelWidth    = 24;

    typedef enum logic [1:0] {
        kIdle,
        kFill,
        kDrain,
        kReady
    } scan_state_t;

    // Frame-buffer pixel layout: {B, G, R}
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

endpackage

// File: rtl/gamma_lut.sv
// Gamma 2.2 correction ROM, 256 x 8, one channel.
// Latency: 1 clock (registered output).
// Backpressure: none; accepts a new index every clock.
// Built only when GAMMA_EN is defined.
// Ports: clock, reset (async, active-high), lut_index (8-bit linear value),
//        lut_value (8-bit corrected value, one clock later).
`ifdef GAMMA_EN
module gamma_lut (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] lut_index,
    output logic [7:0] lut_value
);

    // round(255 * (i/255)^2.2), evaluated at elaboration time only
    function automatic logic [7:0] gamma_entry(input int idx);
        real norm;
        real scaled;
        norm   = real'(idx) / 255.0;
        scaled = 255.0 * (norm ** 2.2) + 0.5;
        return 8'($rtoi(scaled));
    endfunction

    logic [7:0] rom [256];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        localparam logic [7:0] kEntry = gamma_entry(i);
        assign rom[i] = kEntry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lut_value <= '0;
        end else begin
            lut_value <= rom[lut_index];
        end
    end

endmodule
`endif

// File: rtl/scan_sequencer.sv
// Row sequencer feeding the HUB-75 driver from the frame buffer via a ping-pong line buffer.
// Latency: 128 reads + pipeline depth + 1 clocks per row from first read to drv_start.
// Backpressure: holds in kReady until the driver reports idle; never overwrites the displayed half.
// Optional GAMMA_EN: routes each colour channel through gamma_lut, adding one pipeline clock.
// Ports:
//   clock, reset (async, active-high), enable (sampled at row boundaries)
//   fb_read_enable/fb_read_address/fb_read_data : frame-buffer read port, {row, x}
//   lb_write_enable/lb_write_address/lb_write_data : line-buffer write port, {half, x}
//   drv_y, drv_frame_count, drv_start, drv_is_idle : driver handshake
//   frame_sync : pulse with drv_start when drv_y == 0
module scan_sequencer
    import hub75_pkg::*;
#(
    parameter int COLS            = kCols,
    parameter int HALF_ROWS       = kHalfRows,
    parameter int FB_READ_LATENCY = 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        enable,
    output logic                                        fb_read_enable,
    output logic [$clog2(HALF_ROWS)+$clog2(COLS):0]     fb_read_address,
    input  logic [kPixelWidth-1:0]                      fb_read_data,
    output logic                                        lb_write_enable,
    output logic [$clog2(COLS):0]                       lb_write_address,
    output logic [2*kPixelWidth-1:0]                    lb_write_data,
    output logic [$clog2(HALF_ROWS)-1:0]                drv_y,
    output logic [9:0]                                  drv_frame_count,
    output logic                                        drv_start,
    input  logic                                        drv_is_idle,
    output logic                                        frame_sync
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(HALF_ROWS);
    localparam int RW = XW + 1;   // read counter: two reads per column

`ifdef GAMMA_EN
    localparam int kDepth = FB_READ_LATENCY + 1;
`else
    localparam int kDepth = FB_READ_LATENCY;
`endif

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [RW-1:0]     rd_cnt;
    logic [1:0]        drain_cnt;
    logic [YW-1:0]     fill_row;
    logic              fill_half;
    logic              blackout_q;
    logic              blackout;
    logic              issue;

    // Valid/read-index pipeline aligned with returning (and optionally gamma-corrected) data
    logic [kDepth-1:0] vld_pipe;
    logic [RW-1:0]     cnt_pipe [kDepth];
    logic              pix_vld;
    logic [RW-1:0]     pix_cnt;
    pixel_t            pix_in;
    pixel_t            top_latch;

    assign pix_vld = vld_pipe[kDepth-1];
    assign pix_cnt = cnt_pipe[kDepth-1];

    // The driver's idle flag is registered, so it still reads idle right after a start.
    assign blackout = drv_start | blackout_q;

`ifdef GAMMA_EN
    pixel_t     raw_pix;
    logic [7:0] gam_r;
    logic [7:0] gam_g;
    logic [7:0] gam_b;

    assign raw_pix = fb_read_data;

    gamma_lut u_gamma_r (.clock(clock), .reset(reset), .lut_index(raw_pix.r), .lut_value(gam_r));
    gamma_lut u_gamma_g (.clock(clock), .reset(reset), .lut_index(raw_pix.g), .lut_value(gam_g));
    gamma_lut u_gamma_b (.clock(clock), .reset(reset), .lut_index(raw_pix.b), .lut_value(gam_b));

    assign pix_in = '{b: gam_b, g: gam_g, r: gam_r};
`else
    assign pix_in = fb_read_data;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= kIdle;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        fb_read_enable  = 1'b0;
        fb_read_address = '0;
        issue           = 1'b0;
        case (state)
            kIdle: begin
                if (enable) begin
                    state_nxt = kFill;
                end
            end
            kFill: begin
                fb_read_enable = 1'b1;
                // Even r reads the top half row, odd r the matching bottom row (y + HALF_ROWS)
                fb_read_address = {rd_cnt[0], fill_row, rd_cnt[RW-1:1]};
                if (rd_cnt == RW'(2*COLS-1)) begin
                    state_nxt = kDrain;
                end
            end
            kDrain: begin
                if (drain_cnt == 2'(kDepth-1)) begin
                    state_nxt = kReady;
                end
            end
            kReady: begin
                if (drv_is_idle && !blackout) begin
                    issue     = 1'b1;
                    state_nxt = enable ? kFill : kIdle;
                end
            end
            default: begin
                state_nxt = kIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_cnt          <= '0;
            drain_cnt       <= '0;
            fill_row        <= '0;
            fill_half       <= 1'b0;
            drv_y           <= '0;
            drv_frame_count <= 10'h3FF;
            drv_start       <= 1'b0;
            frame_sync      <= 1'b0;
            blackout_q      <= 1'b0;
        end else begin
            rd_cnt     <= (state == kFill) ? rd_cnt + 1'b1 : '0;
            drain_cnt  <= (state == kDrain) ? drain_cnt + 1'b1 : '0;
            drv_start  <= issue;
            frame_sync <= issue && (fill_row == '0);
            blackout_q <= drv_start;
            if (issue) begin
                drv_y           <= fill_row;
                drv_frame_count <= drv_frame_count + 10'd1;
                fill_half       <= ~fill_half;
                fill_row        <= fill_row + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            top_latch <= '0;
            for (int i = 0; i < kDepth; i++) begin
                cnt_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= fb_read_enable;
            cnt_pipe[0] <= rd_cnt;
            for (int i = 1; i < kDepth; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                cnt_pipe[i] <= cnt_pipe[i-1];
            end
            if (pix_vld && !pix_cnt[0]) begin
                top_latch <= pix_in;
            end
        end
    end

    // Odd reads complete a column; fill_half is stable until the row is issued.
    always_comb begin
        lb_write_enable  = pix_vld & pix_cnt[0];
        lb_write_address = '0;
        lb_write_data    = '0;
        if (lb_write_enable) begin
            lb_write_address = {fill_half, pix_cnt[RW-1:1]};
            lb_write_data    = {pix_in, top_latch};
        end
    end

endmodule
